// File: rtl/mux_toggle_tx_pkg.sv
// Shared CDC definitions: toggle-handshake FSM encoding and synchroniser limits.
package mux_toggle_tx_pkg;

    // Transmit-side handshake states.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_GAP      = 2'd2
    } tx_state_e;

    // Fewer than two flops gives no metastability protection.
    localparam int unsigned MIN_SYNC_STAGES = 2;

    // Largest idle gap the 4-bit gap counter can express.
    localparam int unsigned MAX_GAP = 15;

endpackage

// File: rtl/sync_nff.sv
// N-flop single-bit synchroniser with asynchronous active-high reset.
module sync_nff #(
    parameter int unsigned DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_sync;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/mux_toggle_tx.sv
// Toggle-handshake transmitter: registers a word, flips req_tgl, and waits for
// the receiver's synchronised ack toggle to match before accepting the next word.
module mux_toggle_tx
    import mux_toggle_tx_pkg::*;
#(
    parameter int unsigned DW          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned GAP         = 1
) (
    input  logic          clk_b,
    input  logic          brst,
    input  logic [DW-1:0] data_in,
    input  logic          data_vld,
    output logic          data_rdy,
    output logic [DW-1:0] data_out,
    output logic          req_tgl,
    input  logic          ack_tgl,
    output logic          busy,
    output logic          err,
    output logic [7:0]    xfer_cnt
);

    // Clamp parameters into the ranges the hardware supports.
    localparam int unsigned SYNC_N   = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES
                                                                       : SYNC_STAGES;
    localparam int unsigned GAP_C    = (GAP > MAX_GAP) ? MAX_GAP : GAP;
    localparam logic [3:0]  GAP_LOAD = (GAP_C == 0) ? 4'd0 : 4'(GAP_C - 1);

    tx_state_e     r_state;
    tx_state_e     w_state_nxt;
    logic [DW-1:0] r_data;
    logic          r_req;
    logic [3:0]    r_gap_cnt;
    logic          r_err;
    logic [7:0]    r_xfer_cnt;

    logic          w_ack_s;
    logic          w_accept;
    logic          w_ack_done;
    logic          w_proto_err;

    sync_nff #(
        .DEPTH (SYNC_N)
    ) u_ack_sync (
        .i_clk (clk_b),
        .i_rst (brst),
        .i_d   (ack_tgl),
        .o_q   (w_ack_s)
    );

    // Next-state decode and handshake events.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ack_done  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (data_vld) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // Only parity is compared, so a double toggle goes unnoticed.
                if (w_ack_s == r_req) begin
                    w_ack_done  = 1'b1;
                    w_state_nxt = (GAP_C == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outside WAIT_ACK the ack must already agree with our last request.
    always_comb begin
        w_proto_err = 1'b0;
        if ((r_state == S_IDLE) || (r_state == S_GAP)) begin
            w_proto_err = (w_ack_s != r_req);
        end
    end

    // FSM state register.
    always_ff @(posedge clk_b or posedge brst) begin
        if (brst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the word and flip the request only on the accept edge.
    always_ff @(posedge clk_b or posedge brst) begin
        if (brst) begin
            r_data <= '0;
            r_req  <= 1'b0;
        end else if (w_accept) begin
            r_data <= data_in;
            r_req  <= ~r_req;
        end
    end

    // Post-ack idle gap counter: loaded on ack exit, counts down while in GAP.
    always_ff @(posedge clk_b or posedge brst) begin
        if (brst) begin
            r_gap_cnt <= 4'd0;
        end else if (w_ack_done) begin
            r_gap_cnt <= GAP_LOAD;
        end else if ((r_state == S_GAP) && (r_gap_cnt != 4'd0)) begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
        end
    end

    // Sticky protocol-error flag.
    always_ff @(posedge clk_b or posedge brst) begin
        if (brst) begin
            r_err <= 1'b0;
        end else if (w_proto_err) begin
            r_err <= 1'b1;
        end
    end

    // Completed-transfer counter, wraps naturally at 8 bits.
    always_ff @(posedge clk_b or posedge brst) begin
        if (brst) begin
            r_xfer_cnt <= 8'd0;
        end else if (w_ack_done) begin
            r_xfer_cnt <= r_xfer_cnt + 8'd1;
        end
    end

    assign data_rdy = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign data_out = r_data;
    assign req_tgl  = r_req;
    assign err      = r_err;
    assign xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_mux_toggle_tx.sv
// Self-checking bench for mux_toggle_tx: scoreboard of accepted words versus
// words presented on each req_tgl flip, plus directed handshake scenarios.
module tb_mux_toggle_tx;

    localparam int unsigned DW = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned GP = 1;

    logic          clk_b = 1'b0;
    logic          brst  = 1'b0;

    // Main instance (GAP=1), ack either echoed or driven by hand.
    logic [DW-1:0] data_in;
    logic          data_vld;
    logic          data_rdy;
    logic [DW-1:0] data_out;
    logic          req_tgl;
    logic          ack_tgl;
    logic          busy;
    logic          err;
    logic [7:0]    xfer_cnt;
    logic          echo_en;
    logic          ack_man;

    // Second instance (GAP=0) with an always-echoing receiver.
    logic [DW-1:0] data_in0;
    logic          data_vld0;
    logic          data_rdy0;
    logic [DW-1:0] data_out0;
    logic          req_tgl0;
    logic          busy0;
    logic          err0;
    logic [7:0]    xfer_cnt0;

    int            n_chk  = 0;
    int            n_pass = 0;
    int            n_tgl  = 0;

    logic [DW-1:0] sb_q[$];
    logic          prev_req;
    logic [DW-1:0] held_data;

    always #5 clk_b = ~clk_b;

    assign ack_tgl = echo_en ? req_tgl : ack_man;

    mux_toggle_tx #(
        .DW          (DW),
        .SYNC_STAGES (SS),
        .GAP         (GP)
    ) u_dut (
        .clk_b    (clk_b),
        .brst     (brst),
        .data_in  (data_in),
        .data_vld (data_vld),
        .data_rdy (data_rdy),
        .data_out (data_out),
        .req_tgl  (req_tgl),
        .ack_tgl  (ack_tgl),
        .busy     (busy),
        .err      (err),
        .xfer_cnt (xfer_cnt)
    );

    mux_toggle_tx #(
        .DW          (DW),
        .SYNC_STAGES (SS),
        .GAP         (0)
    ) u_dut0 (
        .clk_b    (clk_b),
        .brst     (brst),
        .data_in  (data_in0),
        .data_vld (data_vld0),
        .data_rdy (data_rdy0),
        .data_out (data_out0),
        .req_tgl  (req_tgl0),
        .ack_tgl  (req_tgl0),
        .busy     (busy0),
        .err      (err0),
        .xfer_cnt (xfer_cnt0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int n;
        n = 0;
        while (!data_rdy && n < lim) begin
            @(negedge clk_b);
            n++;
        end
        check(tag, 32'(data_rdy), 32'd1);
    endtask

    // Expected word: whatever was offered on an accepting edge.
    always @(posedge clk_b) begin
        if (!brst && data_vld && data_rdy) begin
            sb_q.push_back(data_in);
        end
    end

    // On each request flip the presented word must be the oldest accepted one;
    // between flips it must not move.
    always @(negedge clk_b) begin
        if (brst) begin
            sb_q.delete();
            prev_req  <= req_tgl;
            held_data <= data_out;
        end else if (req_tgl !== prev_req) begin
            n_tgl <= n_tgl + 1;
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                check("sb_data_out", 32'(data_out), 32'(sb_q.pop_front()));
            end
            prev_req  <= req_tgl;
            held_data <= data_out;
        end else if (busy) begin
            check("data_out_stable", 32'(data_out), 32'(held_data));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base_tgl;
        data_in   = '0;
        data_vld  = 1'b0;
        echo_en   = 1'b1;
        ack_man   = 1'b0;
        data_in0  = '0;
        data_vld0 = 1'b0;

        // Reset values while reset is held.
        #1 brst = 1'b1;
        #2;
        check("rst_rdy",  32'(data_rdy), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        check("rst_req",  32'(req_tgl), 32'd0);
        check("rst_err",  32'(err), 32'd0);
        check("rst_cnt",  32'(xfer_cnt), 32'd0);
        repeat (2) @(negedge clk_b);
        brst = 1'b0;
        @(negedge clk_b);

        // Single transfer with an echoing receiver.
        data_in  = 4'hA;
        data_vld = 1'b1;
        @(negedge clk_b);
        data_vld = 1'b0;
        check("t1_rdy_low", 32'(data_rdy), 32'd0);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk_b);
        end
        check("t1_busy_cycles", 32'(n), 32'(SS + 1 + GP));
        check("t1_dout", 32'(data_out), 32'hA);
        check("t1_req",  32'(req_tgl), 32'd1);
        check("t1_cnt",  32'(xfer_cnt), 32'd1);
        check("t1_err",  32'(err), 32'd0);

        // Back-to-back words with data_vld held; garbage offered while busy.
        base_tgl = n_tgl;
        for (int w = 1; w <= 3; w++) begin
            data_in  = 4'(w);
            data_vld = 1'b1;
            @(negedge clk_b);
            data_in = 4'hF;
            wait_idle("t2_idle", 50);
        end
        data_vld = 1'b0;
        @(negedge clk_b);
        check("t2_toggles", 32'(n_tgl - base_tgl), 32'd3);
        check("t2_dout", 32'(data_out), 32'd3);
        check("t2_cnt",  32'(xfer_cnt), 32'd4);

        // Receiver stalls: no ack, then a single late toggle.
        ack_man  = req_tgl;
        echo_en  = 1'b0;
        data_in  = 4'h5;
        data_vld = 1'b1;
        @(negedge clk_b);
        data_vld = 1'b0;
        repeat (20) @(negedge clk_b);
        check("t3_rdy_low", 32'(data_rdy), 32'd0);
        check("t3_busy",    32'(busy), 32'd1);
        check("t3_dout",    32'(data_out), 32'h5);
        check("t3_cnt",     32'(xfer_cnt), 32'd4);
        ack_man = ~ack_man;
        n = 0;
        while (!data_rdy && n < 50) begin
            @(negedge clk_b);
            n++;
        end
        check("t3_ack_to_rdy", 32'(n), 32'(GP + 1 + SS));
        check("t3_cnt_after",  32'(xfer_cnt), 32'd5);
        echo_en = 1'b1;

        // Spurious ack toggle while idle sets the sticky error.
        ack_man = ~req_tgl;
        echo_en = 1'b0;
        check("t4_err_pre", 32'(err), 32'd0);
        repeat (SS + 1) @(negedge clk_b);
        check("t4_err_set", 32'(err), 32'd1);
        repeat (5) @(negedge clk_b);
        check("t4_err_sticky", 32'(err), 32'd1);
        data_in  = 4'h7;
        data_vld = 1'b1;
        @(negedge clk_b);
        data_vld = 1'b0;
        wait_idle("t4_idle", 50);
        check("t4_cnt", 32'(xfer_cnt), 32'd6);
        check("t4_err_kept", 32'(err), 32'd1);
        echo_en = 1'b1;
        @(negedge clk_b);

        // Reset in the middle of WAIT_ACK.
        data_in  = 4'h9;
        data_vld = 1'b1;
        @(negedge clk_b);
        data_vld = 1'b0;
        @(negedge clk_b);
        check("t5_busy_pre", 32'(busy), 32'd1);
        #2 brst = 1'b1;
        #1;
        check("t5_rdy",  32'(data_rdy), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_dout", 32'(data_out), 32'd0);
        check("t5_req",  32'(req_tgl), 32'd0);
        check("t5_err",  32'(err), 32'd0);
        check("t5_cnt",  32'(xfer_cnt), 32'd0);
        @(negedge clk_b);
        @(negedge clk_b);
        brst = 1'b0;
        @(negedge clk_b);
        check("t5_rdy_post", 32'(data_rdy), 32'd1);
        check("t5_cnt_post", 32'(xfer_cnt), 32'd0);

        // 256 transfers with GAP=0: counter wraps, ready returns right after exit.
        n = 0;
        for (int i = 0; i < 256; i++) begin
            data_in0  = 4'(i);
            data_vld0 = 1'b1;
            @(negedge clk_b);
            data_vld0 = 1'b0;
            n = 0;
            while (!data_rdy0 && n < 50) begin
                @(negedge clk_b);
                n++;
            end
            if (i == 254) begin
                check("t6_cnt_255", 32'(xfer_cnt0), 32'd255);
            end
        end
        check("t6_latency", 32'(n), 32'(SS + 1));
        check("t6_cnt_wrap", 32'(xfer_cnt0), 32'd0);
        check("t6_dout", 32'(data_out0), 32'hF);
        check("t6_err", 32'(err0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
